motor_pwm_drive: RTL and testbench

Two-channel H-bridge PWM driver sitting directly downstream of the PS GPIO output word. Decodes a 32-bit drive command (duty, direction, enable, heartbeat) from the PS, generates glitch-free PWM enable and direction pins for two Pmod H-bridges (left/right wheel), and enforces dead time on every direction change. A heartbeat watchdog forces a safe stop if PS software stalls. A status word is returned for the GPIO input bank.

---
 rtl/motor_pwm_drive.sv | 150 +++++++++++++++
 tb/tb_motor_pwm_drive.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_drive.sv
// rtl/motor_pwm_drive.sv - two-channel H-bridge PWM driver with dead time and heartbeat watchdog
module motor_pwm_drive #(
    parameter int PWM_BITS    = 8,
    parameter int PRESCALE    = 20,
    parameter int DEAD_CYCLES = 1000,
    parameter int WDT_CYCLES  = 10000000
) (
    input  logic        ps_clko,
    input  logic        ps_nrst,
    input  logic [31:0] cmd,
    output logic [1:0]  pwm_en,
    output logic [1:0]  pwm_dir,
    output logic        fault,
    output logic [31:0] status
);

    localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam int WDT_W  = $clog2(WDT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    logic [31:0]         cmd_r;
    logic [PS_W-1:0]     presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [WDT_W-1:0]    wdt;
    logic                hb_prev;
    logic                tick;
    logic                boundary;
    logic                enable;
    logic                heartbeat;
    logic [3:0]          st_all;
    logic [7:0]          cnt_hi;
    logic                unused_bits;

    assign enable      = cmd_r[31];
    assign heartbeat   = cmd_r[30];
    assign tick        = (presc == PS_W'(PRESCALE - 1));
    assign boundary    = tick && (pwm_cnt == '1);
    assign unused_bits = ^cmd_r;

    // Shared timebase for both channels; boundary marks the start of a new PWM period.
    always_ff @(posedge ps_clko or negedge ps_nrst) begin
        if (!ps_nrst) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
        end else begin
            presc   <= presc + 1'b1;
        end
    end

    // A heartbeat edge arriving together with expiry reloads first, so no fault is raised.
    always_ff @(posedge ps_clko or negedge ps_nrst) begin
        if (!ps_nrst) begin
            cmd_r   <= '0;
            hb_prev <= 1'b0;
            wdt     <= WDT_W'(WDT_CYCLES);
            fault   <= 1'b0;
        end else begin
            cmd_r   <= cmd;
            hb_prev <= heartbeat;
            if (!enable) begin
                wdt   <= WDT_W'(WDT_CYCLES);
                fault <= 1'b0;
            end else if (heartbeat != hb_prev) begin
                wdt   <= WDT_W'(WDT_CYCLES);
            end else if (wdt <= WDT_W'(1)) begin
                wdt   <= '0;
                fault <= 1'b1;
            end else begin
                wdt   <= wdt - 1'b1;
            end
        end
    end

    genvar ch;
    for (ch = 0; ch < 2; ch++) begin : g_ch
        state_t              state;
        logic [PWM_BITS-1:0] duty_act;
        logic [DEAD_W-1:0]   dead_cnt;
        logic                dir_q;
        logic [PWM_BITS-1:0] duty_cmd;
        logic                dir_cmd;

        assign duty_cmd = cmd_r[16*ch +: PWM_BITS];
        assign dir_cmd  = cmd_r[16*ch + 8];

        // Direction only ever changes on DEAD exit, when the enable pin has been low for DEAD_CYCLES.
        always_ff @(posedge ps_clko or negedge ps_nrst) begin
            if (!ps_nrst) begin
                state    <= ST_STOP;
                duty_act <= '0;
                dead_cnt <= '0;
                dir_q    <= 1'b0;
            end else begin
                case (state)
                    ST_STOP: begin
                        if (dir_cmd != dir_q) begin
                            state    <= ST_DEAD;
                            dead_cnt <= DEAD_W'(DEAD_CYCLES);
                        end else if (enable && !fault && boundary) begin
                            state    <= ST_RUN;
                            duty_act <= duty_cmd;
                        end
                    end
                    ST_RUN: begin
                        if (!enable || fault) begin
                            state <= ST_STOP;
                        end else if (boundary) begin
                            if (dir_cmd != dir_q) begin
                                state    <= ST_DEAD;
                                dead_cnt <= DEAD_W'(DEAD_CYCLES);
                            end else begin
                                duty_act <= duty_cmd;
                            end
                        end
                    end
                    ST_DEAD: begin
                        dead_cnt <= dead_cnt - 1'b1;
                        if (dead_cnt == DEAD_W'(1)) begin
                            dir_q <= dir_cmd;
                            state <= ST_STOP;
                        end
                    end
                    default: state <= ST_STOP;
                endcase
            end
        end

        assign pwm_en[ch]          = (state == ST_RUN) && (pwm_cnt < duty_act);
        assign pwm_dir[ch]         = dir_q;
        assign st_all[2*ch +: 2]   = state;
    end

    if (PWM_BITS >= 8) begin : g_cnt_hi
        assign cnt_hi = pwm_cnt[PWM_BITS-1 -: 8];
    end else begin : g_cnt_pad
        assign cnt_hi = 8'(pwm_cnt) << (8 - PWM_BITS);
    end

    assign status = {16'b0, cnt_hi, 3'b0, fault, st_all};

endmodule

// File: tb/tb_motor_pwm_drive.sv
// tb/tb_motor_pwm_drive.sv - randomized directed bench for motor_pwm_drive with arithmetic timebase model
module tb_motor_pwm_drive;

    localparam int PRESCALE = 2;
    localparam int DEAD     = 8;
    localparam int WDT      = 2000;
    localparam int PERIOD   = PRESCALE * 256;

    logic        clk = 1'b0;
    logic        ps_nrst = 1'b0;
    logic [31:0] cmd;
    logic [1:0]  pwm_en;
    logic [1:0]  pwm_dir;
    logic        fault;
    logic [31:0] status;

    logic [7:0]  l_duty = 8'h00;
    logic [7:0]  r_duty = 8'h00;
    logic        l_dir = 1'b0;
    logic        r_dir = 1'b0;
    logic        en_bit = 1'b0;
    logic        hb = 1'b0;
    logic        hb_force = 1'b0;
    logic        hb_run = 1'b0;
    logic [6:0]  junk_a = 7'h0;
    logic [4:0]  junk_b = 5'h0;

    logic [7:0]  p_ld = 8'h00;
    logic [7:0]  p_rd = 8'h00;
    logic        p_ldir = 1'b0;

    int          k;
    int          total = 0;
    int          bad = 0;
    int          viol = 0;
    logic [1:0]  prev_dir = 2'b00;
    logic [1:0]  prev_en = 2'b00;
    logic        dir_trace [PERIOD];

    assign cmd = {en_bit, hb ^ hb_force, junk_b, r_dir, r_duty, junk_a, l_dir, l_duty};

    motor_pwm_drive #(
        .PWM_BITS   (8),
        .PRESCALE   (PRESCALE),
        .DEAD_CYCLES(DEAD),
        .WDT_CYCLES (WDT)
    ) dut (
        .ps_clko(clk),
        .ps_nrst(ps_nrst),
        .cmd    (cmd),
        .pwm_en (pwm_en),
        .pwm_dir(pwm_dir),
        .fault  (fault),
        .status (status)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the expected PWM count after edge k is (k/PRESCALE) mod 256.
    always @(posedge clk or negedge ps_nrst) begin
        if (!ps_nrst) k <= 0;
        else          k <= k + 1;
    end

    initial begin
        forever begin
            repeat (500) @(negedge clk);
            if (hb_run) hb = ~hb;
        end
    end

    always @(negedge clk) begin
        if (ps_nrst && (((pwm_dir ^ prev_dir) & (pwm_en | prev_en)) != 2'b00)) viol++;
        prev_dir = pwm_dir;
        prev_en  = pwm_en;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_boundary(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((k % PERIOD) != 0 && n < 2 * PERIOD);
        if ((k % PERIOD) != 0) chk({tag, "_bnd_timeout"}, k % PERIOD, 0);
    endtask

    task automatic wait_offset(input int off);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((k % PERIOD) != off && n < 2 * PERIOD);
        if ((k % PERIOD) != off) chk("offset_timeout", k % PERIOD, off);
    endtask

    // One full period from a boundary: exact waveform plus high-cycle counts; optional mid-period command update.
    task automatic run_period(input int dl, input int dr, input int chg, input string tag);
        int mism = 0;
        int hl = 0;
        int hr = 0;
        int c;
        wait_boundary(tag);
        for (int off = 0; off < PERIOD; off++) begin
            if (off > 0) @(negedge clk);
            c = (k / PRESCALE) % 256;
            if (pwm_en[0] !== (c < dl)) mism++;
            if (pwm_en[1] !== (c < dr)) mism++;
            hl += int'(pwm_en[0]);
            hr += int'(pwm_en[1]);
            dir_trace[off] = pwm_dir[0];
            if (off == chg) begin
                l_duty = p_ld;
                r_duty = p_rd;
                l_dir  = p_ldir;
            end
        end
        chk({tag, "_wave"}, mism, 0);
        chk({tag, "_hi_l"}, hl, dl * PRESCALE);
        chk({tag, "_hi_r"}, hr, dr * PRESCALE);
    endtask

    task automatic check_quiet(input string tag);
        int hi = 0;
        int n = 0;
        while (k < PERIOD - 1 && n < 2 * PERIOD) begin
            @(negedge clk);
            n++;
            if (pwm_en != 2'b00) hi++;
            if (pwm_dir != 2'b00) hi++;
            if (status[3:0] != 4'h0) hi++;
        end
        chk(tag, hi, 0);
    endtask

    initial begin
        int cur_l;
        int cur_r;
        int k0;
        junk_a = 7'($urandom);
        junk_b = 5'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_en", pwm_en, 0);
        chk("rst_dir", pwm_dir, 0);
        chk("rst_fault", fault, 0);
        chk("rst_status", status, 0);

        en_bit  = 1'b1;
        l_duty  = 8'h40;
        r_duty  = 8'h00;
        hb_run  = 1'b1;
        ps_nrst = 1'b1;
        check_quiet("start_quiet");

        p_ld = 8'hC0; p_rd = 8'h00; p_ldir = 1'b0;
        run_period(8'h40, 0, -1, "p1");
        run_period(8'h40, 0, 20, "p2_midchg");
        run_period(8'hC0, 0, -1, "p3");
        chk("run_fault", fault, 0);
        chk("run_dir", pwm_dir, 0);

        cur_l = 8'hC0;
        cur_r = 0;
        for (int i = 0; i < 3; i++) begin
            p_ld = 8'($urandom_range(1, 255));
            p_rd = 8'($urandom_range(0, 255));
            run_period(cur_l, cur_r, $urandom_range(1, 500), "rand");
            cur_l = p_ld;
            cur_r = p_rd;
        end
        run_period(cur_l, cur_r, -1, "rand_last");

        p_ld = 8'h80; p_rd = 8'(cur_r); p_ldir = 1'b0;
        run_period(cur_l, cur_r, 50, "dir_pre");
        run_period(8'h80, cur_r, -1, "dir_run80");
        p_ldir = 1'b1;
        run_period(8'h80, cur_r, 100, "dir_req");
        run_period(0, cur_r, -1, "dir_dead");
        chk("dir_before_flip", dir_trace[DEAD - 1], 0);
        chk("dir_at_flip", dir_trace[DEAD], 1);
        run_period(8'h80, cur_r, -1, "dir_resume");
        chk("dir_after", pwm_dir, 2'b01);

        hb_run = 1'b0;
        repeat (20) @(negedge clk);
        hb_force = ~hb_force;
        k0 = k;
        while (k < k0 + WDT + 1) @(negedge clk);
        chk("wdt_pre", fault, 0);
        @(negedge clk);
        chk("wdt_fault", fault, 1);
        chk("wdt_status4", status[4], 1);
        @(negedge clk);
        chk("wdt_en_off", pwm_en, 0);
        hb_run = 1'b1;
        run_period(0, 0, -1, "fault_hold");
        chk("fault_sticky", fault, 1);
        wait_offset(100);
        en_bit = 1'b0;
        repeat (3) @(negedge clk);
        chk("fault_clear", fault, 0);
        chk("fault_clear_st", status[4], 0);
        en_bit = 1'b1;
        run_period(8'h80, cur_r, -1, "resume");

        p_ld = 8'hFF; p_rd = 8'h00; p_ldir = 1'b1;
        run_period(8'h80, cur_r, 30, "ff_req");
        run_period(8'hFF, 0, -1, "ff_run");
        chk("ff_states", status[3:0], 4'b0101);
        chk("ff_cnt", status[15:8], (k / PRESCALE) % 256);
        chk("ff_zero_bits", {status[31:16], status[7:5]}, 0);

        p_ldir = 1'b0;
        run_period(8'hFF, 0, 40, "rst_req");
        wait_boundary("rst_dead");
        repeat (3) @(negedge clk);
        chk("dead_dir_hold", pwm_dir[0], 1);
        chk("dead_en", pwm_en, 0);
        ps_nrst = 1'b0;
        #1;
        chk("async_en", pwm_en, 0);
        chk("async_dir", pwm_dir, 0);
        chk("async_fault", fault, 0);
        chk("async_status", status, 0);
        @(negedge clk);
        ps_nrst = 1'b1;
        check_quiet("post_rst_quiet");
        run_period(8'hFF, 0, -1, "post_rst_run");
        chk("dir_en_overlap", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
